// File: rtl/pc_sequencer.sv
// Program-counter unit: sequential advance, abs/rel jumps and a circular call/return stack.
// One-cycle update latency; stall freezes all state, including the sticky fault flags.
module pc_sequencer #(
    parameter int          ADDR_W      = 32,
    parameter logic [31:0] RESET_VEC   = 32'h0000_0041,
    parameter int          LEN_W       = 4,
    parameter int          MAX_LEN     = 6,
    parameter int          STACK_DEPTH = 4
) (
    input  logic                             clock_12,
    input  logic                             reset,
    input  logic                             advance,
    input  logic [LEN_W-1:0]                 insn_len,
    input  logic                             stall,
    input  logic                             jump,
    input  logic                             jump_rel,
    input  logic [ADDR_W-1:0]                jump_target,
    input  logic                             call,
    input  logic                             ret,
    output logic [ADDR_W-1:0]                pc,
    output logic [ADDR_W-1:0]                next_seq,
    output logic [$clog2(STACK_DEPTH):0]     stack_count,
    output logic                             ovf,
    output logic                             unf,
    output logic                             bad_len
);
    localparam int PW = $clog2(STACK_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [PW-1:0]     sp, sp_nx;
    logic [CW-1:0]     cnt_nx;
    logic [ADDR_W-1:0] pc_nx, target, top;
    logic              ovf_nx, unf_nx, bad_nx, push;
    logic              len_ok, empty, full;

    assign next_seq = pc + ADDR_W'(insn_len);
    assign target   = jump_rel ? (next_seq + jump_target) : jump_target;
    assign len_ok   = (insn_len != '0) && (insn_len <= LEN_W'(MAX_LEN));
    assign empty    = (stack_count == '0);
    assign full     = (stack_count == CW'(STACK_DEPTH));
    // sp points at the next free slot, so the top of stack sits one below it.
    assign top      = stack_mem[sp - PW'(1)];

    always_comb begin
        pc_nx  = pc;
        sp_nx  = sp;
        cnt_nx = stack_count;
        ovf_nx = ovf;
        unf_nx = unf;
        bad_nx = 1'b0;
        push   = 1'b0;
        if (advance && !stall) begin
            if (!len_ok) begin
                bad_nx = 1'b1;
            end else if (ret) begin
                if (empty) begin
                    unf_nx = 1'b1;
                    pc_nx  = next_seq;
                end else begin
                    pc_nx  = top;
                    sp_nx  = sp - PW'(1);
                    cnt_nx = stack_count - CW'(1);
                end
            end else if (call) begin
                // A full stack overwrites its oldest slot; the count saturates.
                push  = 1'b1;
                pc_nx = target;
                sp_nx = sp + PW'(1);
                if (full) ovf_nx = 1'b1;
                else      cnt_nx = stack_count + CW'(1);
            end else if (jump) begin
                pc_nx = target;
            end else begin
                pc_nx = next_seq;
            end
        end
    end

    always_ff @(posedge clock_12) begin
        if (reset) begin
            pc          <= ADDR_W'(RESET_VEC);
            sp          <= '0;
            stack_count <= '0;
            ovf         <= 1'b0;
            unf         <= 1'b0;
            bad_len     <= 1'b0;
        end else begin
            pc          <= pc_nx;
            sp          <= sp_nx;
            stack_count <= cnt_nx;
            ovf         <= ovf_nx;
            unf         <= unf_nx;
            bad_len     <= bad_nx;
        end
    end

    always_ff @(posedge clock_12) begin
        if (!reset && push) stack_mem[sp] <= next_seq;
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;
    logic        clock_12 = 1'b0;
    logic        reset = 1'b1;
    logic        advance = 1'b0;
    logic [3:0]  insn_len = 4'd1;
    logic        stall = 1'b0;
    logic        jump = 1'b0;
    logic        jump_rel = 1'b0;
    logic [31:0] jump_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc, next_seq;
    logic [2:0]  stack_count;
    logic        ovf, unf, bad_len;

    int checks = 0;
    int failures = 0;

    pc_sequencer dut (
        .clock_12(clock_12), .reset(reset), .advance(advance), .insn_len(insn_len),
        .stall(stall), .jump(jump), .jump_rel(jump_rel), .jump_target(jump_target),
        .call(call), .ret(ret), .pc(pc), .next_seq(next_seq),
        .stack_count(stack_count), .ovf(ovf), .unf(unf), .bad_len(bad_len)
    );

    always #5 clock_12 = ~clock_12;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, sample 1 ns after the edge, then return to idle.
    task automatic cyc(input logic adv, input logic [3:0] len, input logic stl,
                       input logic jmp, input logic rel, input logic [31:0] tgt,
                       input logic cl, input logic rt, input logic rs);
        advance = adv; insn_len = len; stall = stl; jump = jmp; jump_rel = rel;
        jump_target = tgt; call = cl; ret = rt; reset = rs;
        @(posedge clock_12);
        #1;
        advance = 1'b0; stall = 1'b0; jump = 1'b0; jump_rel = 1'b0;
        call = 1'b0; ret = 1'b0; reset = 1'b0;
    endtask

    initial begin
        // reset state
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
        chk("reset_pc", pc, 32'h41);
        chk("reset_cnt", stack_count, 0);
        chk("reset_ovf", ovf, 0);
        chk("reset_unf", unf, 0);
        chk("reset_bad", bad_len, 0);
        insn_len = 4'd6; #1;
        chk("next_seq_comb", next_seq, 32'h47);

        // sequential advance with a stall in the middle
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0); chk("seq_len1", pc, 32'h42);
        cyc(1, 2, 0, 0, 0, 0, 0, 0, 0); chk("seq_len2", pc, 32'h44);
        cyc(1, 3, 1, 0, 0, 0, 0, 0, 0); chk("stall_hold", pc, 32'h44);
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0); chk("seq_len3", pc, 32'h47);
        cyc(1, 6, 0, 0, 0, 0, 0, 0, 0); chk("seq_len6", pc, 32'h4D);

        // jumps; jump without advance is ignored
        cyc(1, 1, 0, 1, 0, 32'h100, 0, 0, 0);        chk("jmp_abs_100", pc, 32'h100);
        cyc(1, 2, 0, 1, 1, 32'hFFFF_FFF0, 0, 0, 0);  chk("jmp_rel_neg", pc, 32'hF2);
        cyc(1, 1, 0, 1, 0, 32'h2000, 0, 0, 0);       chk("jmp_abs_2000", pc, 32'h2000);
        cyc(0, 1, 0, 1, 0, 32'h9000, 0, 0, 0);       chk("jmp_no_adv", pc, 32'h2000);

        // call / ret
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 5, 0, 0, 0, 32'h500, 1, 0, 0);
        chk("call_pc", pc, 32'h500);
        chk("call_cnt", stack_count, 1);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 0);
        chk("ret_pc", pc, 32'h46);
        chk("ret_cnt", stack_count, 0);

        // five calls overflow a depth-4 stack
        cyc(1, 1, 0, 0, 0, 32'h1000, 1, 0, 0);
        cyc(1, 1, 0, 0, 0, 32'h2000, 1, 0, 0);
        cyc(1, 2, 0, 0, 0, 32'h3000, 1, 0, 0);
        cyc(1, 3, 0, 0, 0, 32'h4000, 1, 0, 0);
        chk("full_cnt", stack_count, 4);
        chk("full_no_ovf", ovf, 0);
        cyc(1, 4, 0, 0, 0, 32'h5000, 1, 0, 0);
        chk("ovf_pc", pc, 32'h5000);
        chk("ovf_flag", ovf, 1);
        chk("ovf_cnt", stack_count, 4);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 0); chk("pop1", pc, 32'h4004);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 0); chk("pop2", pc, 32'h3003);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 0); chk("pop3", pc, 32'h2002);
        cyc(1, 1, 0, 0, 0, 0, 0, 1, 0); chk("pop4", pc, 32'h1001);
        chk("pop_cnt0", stack_count, 0);
        chk("no_unf_yet", unf, 0);
        cyc(1, 2, 0, 0, 0, 0, 0, 1, 0);
        chk("unf_flag", unf, 1);
        chk("unf_pc", pc, 32'h1003);

        // illegal lengths
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("bad_len0", bad_len, 1);
        chk("bad_len0_pc", pc, 32'h1003);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("bad_len_pulse", bad_len, 0);
        cyc(1, 7, 0, 0, 0, 32'h7777, 1, 0, 0);
        chk("bad_len7", bad_len, 1);
        chk("bad_len7_pc", pc, 32'h1003);
        chk("bad_len7_cnt", stack_count, 0);
        cyc(1, 7, 1, 0, 0, 0, 0, 0, 0);
        chk("bad_len_stall", bad_len, 0);

        // call + ret together pops only
        cyc(1, 1, 0, 0, 0, 32'h600, 1, 0, 0);
        chk("push_one_cnt", stack_count, 1);
        cyc(1, 2, 0, 0, 0, 32'h700, 1, 1, 0);
        chk("callret_pc", pc, 32'h1004);
        chk("callret_cnt", stack_count, 0);
        chk("sticky_ovf", ovf, 1);

        // address wrap
        cyc(1, 1, 0, 1, 0, 32'hFFFF_FFFE, 0, 0, 0);
        cyc(1, 3, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h1);

        // reset in the middle of a call sequence
        cyc(1, 1, 0, 0, 0, 32'h800, 1, 0, 0);
        chk("pre_rst_cnt", stack_count, 1);
        cyc(1, 1, 0, 0, 0, 32'h900, 1, 0, 1);
        chk("rst_pc", pc, 32'h41);
        chk("rst_cnt", stack_count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_unf", unf, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
